// File: rtl/equal_pkg.sv
// equal_pkg: shared types and constants for the Equal comparator self-test engine.
//   state_t     - driver FSM encoding
//   vec_t       - one table entry {a, b, exp}
//   vec_lookup  - the fixed operand/expected table, indexed 0..7
package equal_pkg;

  localparam int VEC_W     = 8;
  localparam int IDX_W     = 3;
  localparam int NUM_TABLE = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [VEC_W-1:0] a;
    logic [VEC_W-1:0] b;
    logic             exp;
  } vec_t;

  // First half exercises equal pairs (incl. all-zero / all-one), second half
  // unequal pairs with varied bit patterns.
  function automatic vec_t vec_lookup(input logic [IDX_W-1:0] i);
    vec_t v;
    case (i)
      3'd0:    v = '{a: 8'h00, b: 8'h00, exp: 1'b1};
      3'd1:    v = '{a: 8'h10, b: 8'h10, exp: 1'b1};
      3'd2:    v = '{a: 8'hFF, b: 8'hFF, exp: 1'b1};
      3'd3:    v = '{a: 8'h00, b: 8'h00, exp: 1'b1};
      3'd4:    v = '{a: 8'hC6, b: 8'h39, exp: 1'b0};
      3'd5:    v = '{a: 8'hCA, b: 8'hA5, exp: 1'b0};
      3'd6:    v = '{a: 8'h62, b: 8'h38, exp: 1'b0};
      default: v = '{a: 8'h80, b: 8'h00, exp: 1'b0};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/equal_vector_rom.sv
// equal_vector_rom: combinational table lookup, idx -> {a, b, exp}.
//   idx  in   IDX_W  table index
//   vec  out  vec_t  operands and expected equality result
module equal_vector_rom
  import equal_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output vec_t             vec
);

  assign vec = vec_lookup(idx);

endmodule

// File: rtl/equal_vector_driver.sv
// equal_vector_driver: walks the vector table, drives each operand pair onto
// the comparator, waits SETTLE_CYCLES, samples o and scores it.
//   clk, rst_n        clock, async active-low reset
//   start             run request (honoured only in IDLE/DONE)
//   o                 comparator equality output
//   num1, num2        operands to the comparator
//   busy, done        run in progress / run complete
//   pass_cnt/fail_cnt scoring counters
//   fail_seen/fail_idx first-failure flag and index
module equal_vector_driver
  import equal_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,   // 1..15
  parameter int NUM_VEC       = 8    // 1..8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             o,
  output logic [VEC_W-1:0] num1,
  output logic [VEC_W-1:0] num2,
  output logic             busy,
  output logic             done,
  output logic [3:0]       pass_cnt,
  output logic [3:0]       fail_cnt,
  output logic             fail_seen,
  output logic [IDX_W-1:0] fail_idx
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_VEC - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [3:0]       scnt;
  logic             exp_q;
  vec_t             rom_vec;

  logic last_vec, settle_end;
  assign last_vec   = (idx == IDX_LAST);
  assign settle_end = (scnt == SETTLE_LAST);

  equal_vector_rom u_rom (
    .idx (idx),
    .vec (rom_vec)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_LOAD;
      S_LOAD:         state_nxt = S_SETTLE;
      S_SETTLE:       if (settle_end) state_nxt = S_CHECK;
      S_CHECK:        state_nxt = last_vec ? S_DONE : S_LOAD;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // status outputs decode the state register, so they change on the same
  // edges as the state itself (busy falls as done rises).
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_LOAD, S_SETTLE, S_CHECK: busy = 1'b1;
      S_DONE:                    done = 1'b1;
      default: ;
    endcase
  end

  // datapath: operands, settle counter, scoring
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num1      <= '0;
      num2      <= '0;
      exp_q     <= 1'b0;
      idx       <= '0;
      scnt      <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      fail_seen <= 1'b0;
      fail_idx  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          idx       <= '0;
          pass_cnt  <= '0;
          fail_cnt  <= '0;
          fail_seen <= 1'b0;
          fail_idx  <= '0;
        end
        S_LOAD: begin
          num1  <= rom_vec.a;
          num2  <= rom_vec.b;
          exp_q <= rom_vec.exp;
          scnt  <= '0;
        end
        S_SETTLE: scnt <= scnt + 4'd1;
        S_CHECK: begin
          if (o == exp_q) begin
            pass_cnt <= pass_cnt + 4'd1;
          end else begin
            fail_cnt <= fail_cnt + 4'd1;
            if (!fail_seen) begin
              fail_seen <= 1'b1;
              fail_idx  <= idx;
            end
          end
          // idx stays on the last entry through DONE; cleared on restart
          if (!last_vec) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_equal_vector_driver.sv
module tb_equal_vector_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n, start_a, start_b, o_a, o_b;
  logic [7:0] num1_a, num2_a, num1_b, num2_b;
  logic busy_a, done_a, fs_a, busy_b, done_b, fs_b;
  logic [3:0] pc_a, fc_a, pc_b, fc_b;
  logic [2:0] fi_a, fi_b;

  // comparator models: 0 ideal, 1 stuck-0, 2 stuck-1, 3 ideal with random
  // corruption keyed on the low operand bits (stateless, fixed per run)
  int         mode_a = 0;
  logic [7:0] flip_a = '0;

  function automatic logic cmp_model(int mode, logic [7:0] flip, logic [7:0] a, logic [7:0] b);
    case (mode)
      0:       return a == b;
      1:       return 1'b0;
      2:       return 1'b1;
      default: return (a == b) ^ flip[a[2:0]];
    endcase
  endfunction

  assign o_a = cmp_model(mode_a, flip_a, num1_a, num2_a);
  assign o_b = (num1_b == num2_b);

  equal_vector_driver dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .o(o_a),
    .num1(num1_a), .num2(num2_a), .busy(busy_a), .done(done_a),
    .pass_cnt(pc_a), .fail_cnt(fc_a), .fail_seen(fs_a), .fail_idx(fi_a)
  );

  equal_vector_driver #(.SETTLE_CYCLES(5), .NUM_VEC(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .o(o_b),
    .num1(num1_b), .num2(num2_b), .busy(busy_b), .done(done_b),
    .pass_cnt(pc_b), .fail_cnt(fc_b), .fail_seen(fs_b), .fail_idx(fi_b)
  );

  // reference table
  logic [7:0] tab_a [8] = '{8'h00, 8'h10, 8'hFF, 8'h00, 8'hC6, 8'hCA, 8'h62, 8'h80};
  logic [7:0] tab_b [8] = '{8'h00, 8'h10, 8'hFF, 8'h00, 8'h39, 8'hA5, 8'h38, 8'h00};
  logic       tab_e [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  typedef struct {
    int         start_edge;
    int         dur;
    int         pass;
    int         fail;
    bit         seen;
    int         fidx;
    logic [7:0] la, lb;
  } exp_t;

  exp_t qa[$], qb[$];
  int passed = 0, total = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic exp_t model(int mode, logic [7:0] flip, int nvec, int settle, int s);
    exp_t e;
    e.start_edge = s;
    e.dur  = nvec * (settle + 2);
    e.pass = 0; e.fail = 0; e.seen = 0; e.fidx = 0;
    for (int i = 0; i < nvec; i++) begin
      if (cmp_model(mode, flip, tab_a[i], tab_b[i]) == tab_e[i]) e.pass++;
      else begin
        e.fail++;
        if (!e.seen) begin e.seen = 1; e.fidx = i; end
      end
    end
    e.la = tab_a[nvec-1];
    e.lb = tab_b[nvec-1];
    return e;
  endfunction

  // monitors: score each rising done against the oldest expected run
  logic done_qa = 1'b0, done_qb = 1'b0;
  exp_t ea, eb;

  always @(negedge clk) begin
    if (done_a && !done_qa) begin
      if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        ea = qa.pop_front();
        chk("a_latency",  cyc - ea.start_edge, ea.dur);
        chk("a_pass_cnt", int'(pc_a), ea.pass);
        chk("a_fail_cnt", int'(fc_a), ea.fail);
        chk("a_fail_seen", int'(fs_a), int'(ea.seen));
        if (ea.seen) chk("a_fail_idx", int'(fi_a), ea.fidx);
        chk("a_num1_hold", int'(num1_a), int'(ea.la));
        chk("a_num2_hold", int'(num2_a), int'(ea.lb));
        chk("a_busy_at_done", int'(busy_a), 0);
      end
    end
    done_qa <= done_a;
  end

  always @(negedge clk) begin
    if (done_b && !done_qb) begin
      if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("b_latency",  cyc - eb.start_edge, eb.dur);
        chk("b_pass_cnt", int'(pc_b), eb.pass);
        chk("b_fail_cnt", int'(fc_b), eb.fail);
        chk("b_fail_seen", int'(fs_b), int'(eb.seen));
        chk("b_num1_hold", int'(num1_b), int'(eb.la));
        chk("b_num2_hold", int'(num2_b), int'(eb.lb));
      end
    end
    done_qb <= done_b;
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_num1"}, int'(num1_a), 0);
    chk({tag, "_num2"}, int'(num2_a), 0);
    chk({tag, "_busy"}, int'(busy_a), 0);
    chk({tag, "_done"}, int'(done_a), 0);
    chk({tag, "_pass"}, int'(pc_a), 0);
    chk({tag, "_fail"}, int'(fc_a), 0);
    chk({tag, "_seen"}, int'(fs_a), 0);
    chk({tag, "_fidx"}, int'(fi_a), 0);
    chk({tag, "_b_done"}, int'(done_b), 0);
  endtask

  // called at a negedge; returns at a negedge
  task automatic run_a(input int mode, input bit extra);
    int s, n;
    mode_a = mode;
    flip_a = 8'($urandom);
    s = cyc + 1;
    qa.push_back(model(mode, flip_a, 8, 2, s));
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("a_busy_after_start", int'(busy_a), 1);
    if (extra) begin
      repeat (9) @(negedge clk);
      start_a = 1'b1;           // sampled at edge s+10, must be ignored
      @(negedge clk);
      start_a = 1'b0;
    end
    n = 0;
    while (qa.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (qa.size() != 0) begin
      chk("a_done_timeout", 0, 1);
      qa.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int s, n;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    #2;
    check_reset_vals("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_a(0, 0);   // ideal
    run_a(1, 0);   // stuck at 0
    run_a(2, 0);   // stuck at 1
    run_a(0, 1);   // ideal with ignored mid-run start
    run_a(1, 1);
    for (int k = 0; k < 6; k++) run_a(int'($urandom_range(0, 3)), 1'($urandom));

    // mid-run reset at edge 15 of a run
    mode_a = 0;
    s = cyc + 1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    while (cyc < s + 14) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);  // no done may appear without a new start
    chk("midrst_no_done", int'(done_a), 0);
    run_a(0, 0);

    // second configuration, start held high across one restart
    s = cyc + 1;
    qb.push_back(model(0, 8'h00, 3, 5, s));
    qb.push_back(model(0, 8'h00, 3, 5, s + 22));
    start_b = 1'b1;
    while (cyc < s + 22) @(negedge clk);
    start_b = 1'b0;
    chk("b_restart_pass_clr", int'(pc_b), 0);
    chk("b_restart_busy", int'(busy_b), 1);
    chk("b_restart_done", int'(done_b), 0);
    n = 0;
    while (qb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (qb.size() != 0) begin
      chk("b_done_timeout", 0, 1);
      qb.delete();
    end
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
